hline_zbuff_engine: RTL and testbench

Parametrised successor to the hline z-buffer FSM. It draws one z-buffered horizontal span of `dx` pixels in bursts of up to `BURST_LEN` words. For each burst it:
- requests the z-buffer and framebuffer reads,
- pops both input FIFOs,
- interpolates z by Bresenham stepping,
- applies a selectable depth test,
- pushes the results to the output FIFOs,
- requests the two write-backs.

It sits between the span setup registers and the AXI master that owns the four data FIFOs.

---
 rtl/hline_zbuff_engine_pkg.sv | 22 ++
 rtl/hline_zbuff_engine_if.sv | 30 +++
 rtl/hline_zbuff_engine_zinterp.sv | 41 ++++
 rtl/hline_zbuff_engine.sv | 177 +++++++++++++++++
 tb/tb_hline_zbuff_engine.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hline_zbuff_engine_pkg.sv
// Shared types for the hline z-buffer span engine: FSM state encoding and
// depth-test function codes.
package hline_zbuff_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_RD_Z = 3'd1,
        S_RD_F = 3'd2,
        S_PROC = 3'd3,
        S_WR_Z = 3'd4,
        S_WR_F = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    localparam logic [1:0] ZF_LESS    = 2'd0;
    localparam logic [1:0] ZF_LEQUAL  = 2'd1;
    localparam logic [1:0] ZF_GREATER = 2'd2;
    localparam logic [1:0] ZF_ALWAYS  = 2'd3;

endpackage

// File: rtl/hline_zbuff_engine_if.sv
// Bus between the span engine (master) and the AXI block that owns the
// z/frame read FIFOs and the z/frame write FIFOs (slave).
interface hline_zbuff_engine_if #(
    parameter int ADDR_W = 32,
    parameter int Z_W    = 32,
    parameter int LEN_W  = 5
);
    logic              rd_req;
    logic              wr_req;
    logic              sel_z;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              axi_done;
    logic              in_pop;
    logic              out_push;
    logic [Z_W-1:0]    z_in;
    logic [Z_W-1:0]    f_in;
    logic [Z_W-1:0]    z_out;
    logic [Z_W-1:0]    f_out;

    modport master (
        output rd_req, wr_req, sel_z, addr, len, in_pop, out_push, z_out, f_out,
        input  axi_done, z_in, f_in
    );

    modport slave (
        input  rd_req, wr_req, sel_z, addr, len, in_pop, out_push, z_out, f_out,
        output axi_done, z_in, f_in
    );
endinterface

// File: rtl/hline_zbuff_engine_zinterp.sv
// Bresenham z interpolator: holds z_cur/err_cur, loaded at span start and
// stepped once per processed pixel.
module hline_zinterp #(
    parameter int Z_W   = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic             step,
    input  logic [Z_W-1:0]   z_init,
    input  logic [Z_W-1:0]   slope,
    input  logic [CNT_W-1:0] err_init,
    input  logic [CNT_W-1:0] rem,
    input  logic [CNT_W-1:0] dx,
    output logic [Z_W-1:0]   z_cur
);
    logic [CNT_W-1:0] err_cur;
    logic [CNT_W:0]   e;

    // One extra bit so the sign of err_cur - rem survives the subtraction.
    assign e = {1'b0, err_cur} - {1'b0, rem};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            z_cur   <= '0;
            err_cur <= '0;
        end else if (load) begin
            z_cur   <= z_init;
            err_cur <= err_init;
        end else if (step) begin
            if (e[CNT_W]) begin
                err_cur <= e[CNT_W-1:0] + dx;
                z_cur   <= z_cur + slope + Z_W'(1);
            end else begin
                err_cur <= e[CNT_W-1:0];
                z_cur   <= z_cur + slope;
            end
        end
    end
endmodule

// File: rtl/hline_zbuff_engine.sv
// Z-buffered horizontal span engine. Define HLINE_ZBUFF_ZFUNC_EN to decode all
// four zfunc modes; otherwise the depth test is fixed to LESS.
module hline_zbuff_engine
    import hline_zbuff_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int Z_W       = 32,
    parameter int CNT_W     = 16,
    parameter int BURST_LEN = 16
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  fb_addr,
    input  logic [ADDR_W-1:0]  zbuff_addr,
    input  logic [CNT_W-1:0]   dx,
    input  logic [Z_W-1:0]     z1,
    input  logic [Z_W-1:0]     slope,
    input  logic [CNT_W-1:0]   rem,
    input  logic [CNT_W-1:0]   err,
    input  logic [Z_W-1:0]     rgbx,
    input  logic [1:0]         zfunc,
    output logic [STATE_W-1:0] curr_state,
    output logic               busy,
    output logic               done,
    hline_zbuff_engine_if.master bus
);
    localparam int LEN_W = $clog2(BURST_LEN) + 1;

    state_t            state;
    logic              rd_req, wr_req, sel_z;
    logic [ADDR_W-1:0] z_base, fb_base, step_bytes;
    logic [CNT_W-1:0]  remaining, left_next, dx_q, rem_q;
    logic [LEN_W-1:0]  burst_n, pix_cnt;
    logic [Z_W-1:0]    slope_q, rgbx_q, z_cur;
    logic [1:0]        zfunc_q;
    logic              in_proc, req, pass;

    function automatic logic [LEN_W-1:0] burst_of(input logic [CNT_W-1:0] left);
        if (left >= CNT_W'(BURST_LEN)) return LEN_W'(BURST_LEN);
        return LEN_W'(left);
    endfunction

    assign left_next  = remaining - CNT_W'(burst_n);
    assign step_bytes = ADDR_W'(burst_n) << 2;

    // NOTE: state and every registered output use <= so all of them update
    // together from the values sampled at the same edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= S_IDLE;
            rd_req    <= 1'b0;
            wr_req    <= 1'b0;
            sel_z     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            burst_n   <= '0;
            pix_cnt   <= '0;
            z_base    <= '0;
            fb_base   <= '0;
            dx_q      <= '0;
            rem_q     <= '0;
            slope_q   <= '0;
            rgbx_q    <= '0;
            zfunc_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    busy <= 1'b1;
                    if (dx == '0) begin
                        state <= S_FIN;
                    end else begin
                        remaining <= dx;
                        burst_n   <= burst_of(dx);
                        z_base    <= zbuff_addr;
                        fb_base   <= fb_addr;
                        dx_q      <= dx;
                        rem_q     <= rem;
                        slope_q   <= slope;
                        rgbx_q    <= rgbx;
                        zfunc_q   <= zfunc;
                        rd_req    <= 1'b1;
                        sel_z     <= 1'b1;
                        state     <= S_RD_Z;
                    end
                end
                S_RD_Z: if (bus.axi_done) begin
                    sel_z <= 1'b0;
                    state <= S_RD_F;
                end
                S_RD_F: if (bus.axi_done) begin
                    rd_req  <= 1'b0;
                    pix_cnt <= burst_n;
                    state   <= S_PROC;
                end
                S_PROC: begin
                    pix_cnt <= pix_cnt - LEN_W'(1);
                    if (pix_cnt == LEN_W'(1)) begin
                        wr_req <= 1'b1;
                        sel_z  <= 1'b1;
                        state  <= S_WR_Z;
                    end
                end
                S_WR_Z: if (bus.axi_done) begin
                    sel_z <= 1'b0;
                    state <= S_WR_F;
                end
                S_WR_F: if (bus.axi_done) begin
                    wr_req    <= 1'b0;
                    z_base    <= z_base + step_bytes;
                    fb_base   <= fb_base + step_bytes;
                    remaining <= left_next;
                    if (left_next == '0) begin
                        state <= S_FIN;
                    end else begin
                        burst_n <= burst_of(left_next);
                        rd_req  <= 1'b1;
                        sel_z   <= 1'b1;
                        state   <= S_RD_Z;
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    hline_zinterp #(.Z_W(Z_W), .CNT_W(CNT_W)) u_zinterp (
        .clk      (clk),
        .nreset   (nreset),
        .load     (state == S_IDLE && start),
        .step     (in_proc),
        .z_init   (z1),
        .slope    (slope_q),
        .err_init (err),
        .rem      (rem_q),
        .dx       (dx_q),
        .z_cur    (z_cur)
    );

`ifdef HLINE_ZBUFF_ZFUNC_EN
    // NOTE: pass gets a default before the case so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        pass = 1'b1;
        case (zfunc_q)
            ZF_LESS:    pass = z_cur <  bus.z_in;
            ZF_LEQUAL:  pass = z_cur <= bus.z_in;
            ZF_GREATER: pass = z_cur >  bus.z_in;
            default:    pass = 1'b1;
        endcase
    end
`else
    logic unused_zfunc;
    assign unused_zfunc = ^zfunc_q;
    assign pass = z_cur < bus.z_in;
`endif

    assign in_proc      = state == S_PROC;
    assign req          = rd_req | wr_req;
    assign curr_state   = state;
    assign bus.rd_req   = rd_req;
    assign bus.wr_req   = wr_req;
    assign bus.sel_z    = sel_z;
    assign bus.addr     = !req ? '0 : (sel_z ? z_base : fb_base);
    assign bus.len      = req ? burst_n : '0;
    assign bus.in_pop   = in_proc;
    assign bus.out_push = in_proc;
    assign bus.z_out    = !in_proc ? '0 : (pass ? z_cur : bus.z_in);
    assign bus.f_out    = !in_proc ? '0 : (pass ? rgbx_q : bus.f_in);
endmodule

// File: tb/tb_hline_zbuff_engine.sv
// Scoreboard bench for hline_zbuff_engine: a bench-side span model fills
// expected pixel and request queues that are drained as the DUT produces them.
module tb_hline_zbuff_engine;

    typedef struct packed {
        logic [31:0] z;
        logic [31:0] f;
    } pix_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        sz;
        logic [31:0] addr;
        logic [4:0]  len;
    } req_t;

    logic        clk, nreset, start, busy, done;
    logic [31:0] fb_addr, zbuff_addr, z1, slope, rgbx;
    logic [15:0] dx, rem, err;
    logic [1:0]  zfunc;
    logic [2:0]  curr_state;

    int   n_cmp = 0;
    int   n_bad = 0;
    pix_t exp_pix[$];
    req_t exp_req[$];

    hline_zbuff_engine_if #(.ADDR_W(32), .Z_W(32), .LEN_W(5)) bus ();

    hline_zbuff_engine #(.ADDR_W(32), .Z_W(32), .CNT_W(16), .BURST_LEN(16)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .start      (start),
        .fb_addr    (fb_addr),
        .zbuff_addr (zbuff_addr),
        .dx         (dx),
        .z1         (z1),
        .slope      (slope),
        .rem        (rem),
        .err        (err),
        .rgbx       (rgbx),
        .zfunc      (zfunc),
        .curr_state (curr_state),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] head_z(input logic [31:0] b, input logic [31:0] s, input int i);
        return b + s * i;
    endfunction

    function automatic logic [31:0] head_f(input int i);
        return 32'hF00D_0000 + i;
    endfunction

    function automatic bit pass_fn(input logic [1:0] zf, input logic [31:0] zc, input logic [31:0] zi);
`ifdef HLINE_ZBUFF_ZFUNC_EN
        case (zf)
            2'd0:    return zc < zi;
            2'd1:    return zc <= zi;
            2'd2:    return zc > zi;
            default: return 1'b1;
        endcase
`else
        return (zf == zf) && (zc < zi);
`endif
    endfunction

    task automatic push_model(input logic [15:0] dx_i, input logic [31:0] z1_i, input logic [31:0] slope_i,
                              input logic [15:0] rem_i, input logic [15:0] err_i, input logic [31:0] rgbx_i,
                              input logic [1:0] zf_i, input logic [31:0] zb_i, input logic [31:0] fb_i,
                              input logic [31:0] zin_b, input logic [31:0] zin_s);
        logic [31:0] z, zi, zb, fb;
        int e, t, left, n;
        z = z1_i;
        e = int'(err_i);
        for (int i = 0; i < int'(dx_i); i++) begin
            zi = head_z(zin_b, zin_s, i);
            if (pass_fn(zf_i, z, zi)) exp_pix.push_back({z, rgbx_i});
            else                      exp_pix.push_back({zi, head_f(i)});
            t = e - int'(rem_i);
            if (t < 0) begin e = t + int'(dx_i); z = z + slope_i + 32'd1; end
            else       begin e = t;              z = z + slope_i;         end
        end
        zb = zb_i; fb = fb_i; left = int'(dx_i);
        while (left > 0) begin
            n = (left > 16) ? 16 : left;
            exp_req.push_back({1'b1, 1'b0, 1'b1, zb, 5'(n)});
            exp_req.push_back({1'b1, 1'b0, 1'b0, fb, 5'(n)});
            exp_req.push_back({1'b0, 1'b1, 1'b1, zb, 5'(n)});
            exp_req.push_back({1'b0, 1'b1, 1'b0, fb, 5'(n)});
            zb = zb + 32'(4 * n); fb = fb + 32'(4 * n); left = left - n;
        end
    endtask

    task automatic run_span(input string name, input logic [15:0] dx_i, input logic [31:0] z1_i,
                            input logic [31:0] slope_i, input logic [15:0] rem_i, input logic [15:0] err_i,
                            input logic [1:0] zf_i, input logic [31:0] zb_i, input logic [31:0] fb_i,
                            input logic [31:0] zin_b, input logic [31:0] zin_s, input bit poke);
        int idx, dones, after, wait_cnt;
        bit open, poked, finished;
        pix_t p;
        req_t r, g;
        push_model(dx_i, z1_i, slope_i, rem_i, err_i, 32'h00AA_BBCC, zf_i, zb_i, fb_i, zin_b, zin_s);
        @(negedge clk);
        dx = dx_i; z1 = z1_i; slope = slope_i; rem = rem_i; err = err_i; rgbx = 32'h00AA_BBCC;
        zfunc = zf_i; zbuff_addr = zb_i; fb_addr = fb_i; start = 1'b1;
        idx = 0; bus.z_in = head_z(zin_b, zin_s, 0); bus.f_in = head_f(0);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({bus.rd_req, busy, curr_state} !== {1'b1, 1'b1, 3'd1}) begin
            n_bad++;
            $display("FAIL %s start_latency: got rd_req/busy/state=%b/%b/%0d, expected 1/1/1", name, bus.rd_req, busy, curr_state);
        end
        dones = 0; after = 0; open = 0; poked = 0; finished = 0; wait_cnt = 0;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = 1'b0;
            bus.axi_done = 1'b0;
            if (done === 1'b1) dones++;
            if (bus.in_pop === 1'b1) begin
                if (poke && !poked) begin start = 1'b1; bus.axi_done = 1'b1; poked = 1; end
                n_cmp++;
                if (exp_pix.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s extra_pixel: got z_out=%h, expected no pixel", name, bus.z_out);
                end else begin
                    p = exp_pix.pop_front();
                    if ({bus.out_push, bus.z_out, bus.f_out} !== {1'b1, p.z, p.f}) begin
                        n_bad++;
                        $display("FAIL %s pixel%0d: got push=%b z=%h f=%h, expected push=1 z=%h f=%h",
                                 name, idx, bus.out_push, bus.z_out, bus.f_out, p.z, p.f);
                    end
                end
                idx++;
                bus.z_in = head_z(zin_b, zin_s, idx);
                bus.f_in = head_f(idx);
            end
            if (bus.rd_req === 1'b1 || bus.wr_req === 1'b1) begin
                if (!open) begin
                    g = {bus.rd_req, bus.wr_req, bus.sel_z, bus.addr, bus.len};
                    n_cmp++;
                    if (exp_req.size() == 0) begin
                        n_bad++;
                        $display("FAIL %s extra_request: got %h, expected none", name, g);
                    end else begin
                        r = exp_req.pop_front();
                        if (g !== r) begin
                            n_bad++;
                            $display("FAIL %s request: got rd=%b wr=%b sel_z=%b addr=%h len=%0d, expected rd=%b wr=%b sel_z=%b addr=%h len=%0d",
                                     name, g.rd, g.wr, g.sz, g.addr, g.len, r.rd, r.wr, r.sz, r.addr, r.len);
                        end
                    end
                    open = 1;
                    wait_cnt = int'($urandom_range(0, 2));
                end
                if (wait_cnt == 0) begin bus.axi_done = 1'b1; open = 0; end
                else wait_cnt--;
            end
            if (dones > 0) begin
                after++;
                if (after > 3) finished = 1;
            end
        end
        n_cmp++;
        if (!finished || dones != 1) begin
            n_bad++;
            $display("FAIL %s done_count: got %0d done cycles (finished=%0b), expected 1", name, dones, finished);
        end
        n_cmp++;
        if (exp_pix.size() != 0 || exp_req.size() != 0 || curr_state !== 3'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s end_state: got pix_left=%0d req_left=%0d state=%0d busy=%b, expected 0/0/0/0",
                     name, exp_pix.size(), exp_req.size(), curr_state, busy);
        end
        exp_pix.delete();
        exp_req.delete();
        bus.axi_done = 1'b0;
    endtask

    task automatic test_reset();
        nreset = 1'b0; start = 1'b0; dx = '0; z1 = '0; slope = '0; rem = '0; err = '0; rgbx = '0;
        zfunc = '0; fb_addr = '0; zbuff_addr = '0;
        bus.axi_done = 1'b0; bus.z_in = 32'h1234_5678; bus.f_in = 32'h9ABC_DEF0;
        #12;
        n_cmp++;
        if ({curr_state, busy, done} !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got state=%0d busy=%b done=%b, expected 0/0/0", curr_state, busy, done);
        end
        n_cmp++;
        if ({bus.rd_req, bus.wr_req, bus.sel_z, bus.addr, bus.len} !== '0) begin
            n_bad++;
            $display("FAIL reset_req: got rd=%b wr=%b sel=%b addr=%h len=%0d, expected all 0",
                     bus.rd_req, bus.wr_req, bus.sel_z, bus.addr, bus.len);
        end
        n_cmp++;
        if ({bus.in_pop, bus.out_push, bus.z_out, bus.f_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got pop=%b push=%b z=%h f=%h, expected all 0",
                     bus.in_pop, bus.out_push, bus.z_out, bus.f_out);
        end
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_long_span();
        run_span("long_span", 16'd20, 32'd0, 32'h0001_0000, 16'd0, 16'd0, 2'd0,
                 32'h1000_0000, 32'h2000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0);
    endtask

    task automatic test_bresenham();
        run_span("bresenham", 16'd4, 32'd10, 32'd0, 16'd1, 16'd2, 2'd0,
                 32'h0000_1000, 32'h0000_2000, 32'd100, 32'd0, 1'b0);
        run_span("mixed", 16'd7, 32'd100, 32'd5, 16'd3, 16'd1, 2'd0,
                 32'h0000_3000, 32'h0000_4000, 32'd110, 32'd2, 1'b0);
    endtask

    task automatic test_zfunc();
        for (int m = 0; m < 4; m++)
            run_span($sformatf("zfunc_eq%0d", m), 16'd3, 32'h55, 32'd0, 16'd0, 16'd0, 2'(m),
                     32'h0000_5000, 32'h0000_6000, 32'h55, 32'd0, 1'b0);
        run_span("zfunc_greater", 16'd2, 32'h55, 32'd0, 16'd0, 16'd0, 2'd2,
                 32'h0000_5000, 32'h0000_6000, 32'h40, 32'd0, 1'b0);
    endtask

    task automatic test_dx_zero();
        bit saw_req;
        @(negedge clk);
        dx = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw_req = bus.rd_req | bus.wr_req;
        n_cmp++;
        if ({done, curr_state} !== {1'b0, 3'd6}) begin
            n_bad++;
            $display("FAIL dx0_fin: got done=%b state=%0d, expected 0/6", done, curr_state);
        end
        @(negedge clk);
        saw_req |= bus.rd_req | bus.wr_req;
        n_cmp++;
        if ({done, curr_state} !== {1'b1, 3'd0}) begin
            n_bad++;
            $display("FAIL dx0_done: got done=%b state=%0d, expected 1/0", done, curr_state);
        end
        @(negedge clk);
        saw_req |= bus.rd_req | bus.wr_req;
        n_cmp++;
        if (done !== 1'b0 || saw_req) begin
            n_bad++;
            $display("FAIL dx0_after: got done=%b saw_req=%b, expected 0/0", done, saw_req);
        end
    endtask

    task automatic test_reset_mid_span();
        bit saw_wrz, bad;
        saw_wrz = 0; bad = 0;
        @(negedge clk);
        dx = 16'd20; z1 = 32'd0; slope = 32'd1; rem = 16'd0; err = 16'd0; zfunc = 2'd0;
        zbuff_addr = 32'h0000_7000; fb_addr = 32'h0000_8000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            bus.axi_done = 1'b0;
            if (curr_state === 3'd4) begin saw_wrz = 1; break; end
            if (bus.rd_req === 1'b1) bus.axi_done = 1'b1;
            @(negedge clk);
        end
        bus.axi_done = 1'b0;
        n_cmp++;
        if (!saw_wrz) begin
            n_bad++;
            $display("FAIL rst_mid_reach: got state=%0d, expected 4", curr_state);
        end
        nreset = 1'b0;
        #1;
        n_cmp++;
        if ({curr_state, busy, done, bus.rd_req, bus.wr_req, bus.sel_z, bus.addr, bus.len,
             bus.in_pop, bus.out_push, bus.z_out, bus.f_out} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got state=%0d busy=%b wr=%b addr=%h len=%0d, expected all 0",
                     curr_state, busy, bus.wr_req, bus.addr, bus.len);
        end
        @(negedge clk);
        nreset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || bus.rd_req !== 1'b0 || bus.wr_req !== 1'b0 || curr_state !== 3'd0) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL rst_mid_quiet: got activity after reset, expected idle with no done");
        end
        run_span("after_reset", 16'd20, 32'd7, 32'd3, 16'd2, 16'd5, 2'd0,
                 32'h0000_9000, 32'h0000_A000, 32'd40, 32'd1, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        @(negedge clk);
        bus.axi_done = 1'b1;
        @(negedge clk);
        bus.axi_done = 1'b0;
        n_cmp++;
        if ({curr_state, busy, bus.rd_req, bus.wr_req, bus.addr} !== '0) begin
            n_bad++;
            $display("FAIL idle_axi_done: got state=%0d busy=%b rd=%b wr=%b addr=%h, expected all 0",
                     curr_state, busy, bus.rd_req, bus.wr_req, bus.addr);
        end
        run_span("poke_in_proc", 16'd18, 32'd3, 32'd2, 16'd1, 16'd0, 2'd0,
                 32'h0000_B000, 32'h0000_C000, 32'd30, 32'd1, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_span("wrap_three_bursts", 16'd33, 32'hFFFF_FFF0, 32'd1, 16'd5, 16'd3, 2'd0,
                 32'hFFFF_FFC0, 32'hFFFF_FF80, 32'hFFFF_FFF8, 32'd0, 1'b0);
        run_span("back_to_back", 16'd5, 32'd1, 32'd1, 16'd0, 16'd0, 2'd0,
                 32'h0000_D000, 32'h0000_E000, 32'd4, 32'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_long_span();
        test_bresenham();
        test_zfunc();
        test_dx_zero();
        test_reset_mid_span();
        test_ignored_inputs();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
